// File: rtl/q2_alu_seq.sv
// Bit-serial sequencer for the q2 ALU slice: streams A/X LSB-first through an external 1-bit slice.
// Optional feature: define Q2_ALU_SEQ_ABORT_EN to add the abort port (cancel a running operation).
module q2_alu_seq #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             cin,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             a0,
    output logic             x0,
    output logic             x1,
    output logic             f,
    output logic             op3,
    output logic             op4,
    input  logic             alu_out,
`ifdef Q2_ALU_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             alu_cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   x_sr_q, x_sr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         op_q, op_d;
    logic               f_q, f_d;
    logic               cin_r_q, cin_r_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_bit;
    logic               running;
    logic               abort_hit;

`ifdef Q2_ALU_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign running  = (state_q == RUN);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        x_sr_d   = x_sr_q;
        result_d = result_q;
        op_d     = op_q;
        f_d      = f_q;
        cin_r_d  = cin_r_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a_in;
                    x_sr_d  = x_in;
                    op_d    = op_in;
                    f_d     = cin;
                    cin_r_d = cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                result_d = {alu_out, result_q[WIDTH-1:1]};
                f_d      = alu_cout;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                x_sr_d   = {1'b0, x_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = DONE;
                    carry_d = alu_cout;
                end
                // Abort wins over the final bit so a cancelled op never reaches DONE.
                if (abort_hit) begin
                    state_d  = IDLE;
                    result_d = '0;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            x_sr_q   <= '0;
            result_q <= '0;
            op_q     <= 2'b00;
            f_q      <= 1'b0;
            cin_r_q  <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            x_sr_q   <= x_sr_d;
            result_q <= result_d;
            op_q     <= op_d;
            f_q      <= f_d;
            cin_r_q  <= cin_r_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    // On the MSB the slice's "next bit" input carries cin so SHR can fill the top.
    assign a0  = running & a_sr_q[0];
    assign x0  = running & x_sr_q[0];
    assign x1  = running & (last_bit ? cin_r_q : x_sr_q[1]);
    assign f   = running & f_q;
    assign op3 = running & op_q[0];
    assign op4 = running & op_q[1];

    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign result      = result_q;
    assign carry_out   = carry_q;

endmodule

// File: tb/tb_q2_alu_seq.sv
// Self-checking bench for q2_alu_seq: contains a stand-in model of the 1-bit ALU slice
// plus a word-level reference model; define Q2_ALU_SEQ_ABORT_EN to exercise abort.
module tb_q2_alu_seq;

    localparam int W = 12;

    logic          clk;
    logic          rst;
    logic          start;
    logic          start_ready;
    logic [1:0]    op_in;
    logic [W-1:0]  a_in;
    logic [W-1:0]  x_in;
    logic          cin;
    logic          done_valid;
    logic          done_ready;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          a0, x0, x1, f, op3, op4;
    logic          alu_out;
    logic          alu_cout;
`ifdef Q2_ALU_SEQ_ABORT_EN
    logic          abort;
`endif

    int n_checks;
    int n_pass;

    q2_alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_ready (start_ready),
        .op_in       (op_in),
        .a_in        (a_in),
        .x_in        (x_in),
        .cin         (cin),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .result      (result),
        .carry_out   (carry_out),
        .a0          (a0),
        .x0          (x0),
        .x1          (x1),
        .f           (f),
        .op3         (op3),
        .op4         (op4),
        .alu_out     (alu_out),
`ifdef Q2_ALU_SEQ_ABORT_EN
        .abort       (abort),
`endif
        .alu_cout    (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external 1-bit slice.
    always_comb begin
        alu_out  = 1'b0;
        alu_cout = 1'b0;
        case ({op4, op3})
            2'b00: begin alu_out = x0;          alu_cout = f & ~x0; end
            2'b01: begin alu_out = ~(a0 | x0);  alu_cout = f & ~(~(a0 | x0)); end
            2'b10: begin alu_out = a0 ^ x0 ^ f; alu_cout = (a0 & x0) | (a0 & f) | (x0 & f); end
            default: begin alu_out = x1;        alu_cout = f; end
        endcase
    end

    // Word-level reference: {carry, result}.
    function automatic logic [W:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] x, input logic c);
        logic [W-1:0] r;
        logic [W:0]   s;
        case (op)
            2'b00:   ref_op = {c & (x == '0), x};
            2'b01: begin r = ~(a | x); ref_op = {c & (r == '0), r}; end
            2'b10: begin s = {1'b0, a} + {1'b0, x} + {{W{1'b0}}, c}; ref_op = s; end
            default: ref_op = {c, c, x[W-1:1]};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] x,
                          input logic c);
        @(negedge clk);
        checkOutput("start_ready_idle", start_ready, 1);
        start = 1'b1; op_in = op; a_in = a; x_in = x; cin = c;
        @(posedge clk); #1;
        start = 1'b0;
        op_in = 2'($urandom); a_in = W'($urandom); x_in = W'($urandom); cin = 1'($urandom);
    endtask

    // Accept an op and wait for done_valid; lat counts cycles from the accept cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] x,
                                 input logic c, output logic [W-1:0] res, output logic co,
                                 output int lat);
        launch(op, a, x, c);
        lat = 1;
        while (!done_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        co  = carry_out;
    endtask

    task automatic release_done();
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        checkOutput("back_to_idle", {start_ready, done_valid}, 2'b10);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] x;
        logic         c;
        logic [W-1:0] res;
        logic         co;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [W-1:0] r;
        logic         co;
        int           lat;
        logic [W:0]   exp_v;
        logic [1:0]   op;
        logic [W-1:0] a, x;
        logic         c;
        bit           seen;

        n_checks = 0;
        n_pass   = 0;
        vecs[0] = '{2'b10, 12'h0FF, 12'h001, 1'b0, 12'h100, 1'b0};
        vecs[1] = '{2'b10, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1};
        vecs[2] = '{2'b01, 12'hF0F, 12'h0F0, 1'b1, 12'h000, 1'b1};
        vecs[3] = '{2'b00, 12'h5A5, 12'h000, 1'b1, 12'h000, 1'b1};
        vecs[4] = '{2'b00, 12'h000, 12'h800, 1'b1, 12'h800, 1'b0};
        vecs[5] = '{2'b11, 12'h000, 12'h003, 1'b1, 12'h801, 1'b1};
        vecs[6] = '{2'b10, 12'h123, 12'h456, 1'b1, 12'h57A, 1'b0};
        vecs[7] = '{2'b01, 12'h000, 12'h000, 1'b1, 12'hFFF, 1'b0};
        vecs[8] = '{2'b11, 12'h000, 12'hFFE, 1'b0, 12'h7FF, 1'b0};

        rst = 1'b1; start = 1'b0; done_ready = 1'b0;
        op_in = '0; a_in = '0; x_in = '0; cin = 1'b0;
`ifdef Q2_ALU_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready_valid", {start_ready, done_valid}, 2'b10);
        checkOutput("reset_result", {result, carry_out}, 0);
        checkOutput("reset_slice", {a0, x0, x1, f, op3, op4}, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].x, vecs[i].c, r, co, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, W + 1);
            checkOutput($sformatf("vec%0d_result", i), r, vecs[i].res);
            checkOutput($sformatf("vec%0d_carry", i), co, vecs[i].co);
            release_done();
        end

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom); a = W'($urandom); x = W'($urandom); c = 1'($urandom);
            exp_v = ref_op(op, a, x, c);
            applyStimulus(op, a, x, c, r, co, lat);
            checkOutput($sformatf("rnd%0d_latency", i), lat, W + 1);
            checkOutput($sformatf("rnd%0d_result op%0d", i, op), r, exp_v[W-1:0]);
            checkOutput($sformatf("rnd%0d_carry op%0d", i, op), co, exp_v[W]);
            release_done();
        end

        // Hold DONE with start asserted: nothing new may be accepted.
        applyStimulus(2'b10, 12'h0A5, 12'h05A, 1'b0, r, co, lat);
        checkOutput("hold_first", r, 12'h0FF);
        @(negedge clk);
        start = 1'b1; op_in = 2'b00; x_in = 12'h123; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("hold%0d_state", i), {start_ready, done_valid}, 2'b01);
            checkOutput($sformatf("hold%0d_result", i), {carry_out, result}, {1'b0, 12'h0FF});
        end
        @(negedge clk);
        start = 1'b0; done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        checkOutput("hold_release", {start_ready, done_valid}, 2'b10);

        // Synchronous reset in the middle of an ADD.
        launch(2'b10, 12'hFFF, 12'hFFF, 1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_state", {start_ready, done_valid}, 2'b10);
        checkOutput("rst_mid_result", {result, carry_out}, 0);
        checkOutput("rst_mid_slice", {a0, x0, x1, f, op3, op4}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (done_valid) seen = 1'b1;
        end
        checkOutput("rst_mid_no_done", seen, 0);
        applyStimulus(2'b10, 12'h001, 12'h001, 1'b0, r, co, lat);
        checkOutput("after_rst_result", {co, r}, {1'b0, 12'h002});
        release_done();

`ifdef Q2_ALU_SEQ_ABORT_EN
        launch(2'b10, 12'h777, 12'h111, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_state", {start_ready, done_valid}, 2'b10);
        checkOutput("abort_result", result, 0);
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (done_valid) seen = 1'b1;
        end
        checkOutput("abort_no_done", seen, 0);
        applyStimulus(2'b10, 12'h0FF, 12'h001, 1'b0, r, co, lat);
        checkOutput("after_abort_result", {co, r}, {1'b0, 12'h100});
        release_done();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
